// File: rtl/lfsr32_digit_source.sv
// 32-bit Galois LFSR source for the eight HEX digit decoders. It advances from a
// free-running prescaled tick or a debounced push button. Define LFSR_DIGIT_HOLD_EN
// to add the hold_i display freeze.
module lfsr32_digit_source #(
    parameter logic [31:0] SEED       = 32'hACE1_2468,
    parameter logic [31:0] TAPS       = 32'h8020_0003,
    parameter int          PRESCALE   = 50_000_000,
    parameter int          DEB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        step_n_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
`ifdef LFSR_DIGIT_HOLD_EN
    input  logic        hold_i,
`endif
    output logic [31:0] lfsr_o,
    output logic [31:0] digits_o,
    output logic        advance_o,
    output logic        zero_fix_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    sync_fill;
    logic          armed;
    logic          deb_level;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] presc_cnt;

    logic          deb_expire;
    logic          step_pulse;
    logic          tick;
    logic          advance;
    logic [31:0]   shifted;
    logic [31:0]   load_value;

    // The arm flag holds off pulses until a genuine released sample has been
    // seen, so a button held through reset cannot fire a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync1     <= step_n_i;
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & sync2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (sync2 == deb_level) begin
            deb_cnt   <= '0;
        end else if (deb_expire) begin
            deb_level <= sync2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt   <= deb_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!run_i || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    // The step pulse coincides with the cycle in which the debounced level commits to 0.
    always_comb begin
        deb_expire = (sync2 != deb_level) && (deb_cnt == DW'(DEB_CYCLES - 1));
        step_pulse = deb_expire & ~sync2 & armed;
        tick       = run_i && (presc_cnt == PW'(PRESCALE - 1));
        advance    = (run_i & tick) | (~run_i & step_pulse);
        shifted    = {1'b0, lfsr_o[31:1]} ^ (lfsr_o[0] ? TAPS : 32'h0);
        load_value = (seed_i == 32'h0) ? SEED : seed_i;
    end

    // A load wins over a coincident advance, which is dropped rather than deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_o     <= SEED;
            advance_o  <= 1'b0;
            zero_fix_o <= 1'b0;
        end else if (load_i) begin
            lfsr_o     <= load_value;
            advance_o  <= 1'b0;
            if (seed_i == 32'h0) begin
                zero_fix_o <= 1'b1;
            end
        end else if (lfsr_o == 32'h0) begin
            lfsr_o     <= SEED;
            advance_o  <= 1'b0;
        end else if (advance) begin
            lfsr_o     <= shifted;
            advance_o  <= 1'b1;
        end else begin
            advance_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o <= SEED;
`ifdef LFSR_DIGIT_HOLD_EN
        end else if (!hold_i) begin
            digits_o <= lfsr_o;
`else
        end else begin
            digits_o <= lfsr_o;
`endif
        end
    end

endmodule

// File: tb/tb_lfsr32_digit_source.sv
// Directed self-checking bench for lfsr32_digit_source with PRESCALE=4, DEB_CYCLES=3.
// Covers the LFSR_DIGIT_HOLD_EN freeze when that macro is defined.
module tb_lfsr32_digit_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step_n;
    logic        load;
    logic [31:0] seed;
`ifdef LFSR_DIGIT_HOLD_EN
    logic        hold;
`endif
    logic [31:0] lfsr;
    logic [31:0] digits;
    logic        advance;
    logic        zero_fix;

    int checks = 0;
    int errors = 0;

    lfsr32_digit_source #(
        .SEED       (32'hACE1_2468),
        .TAPS       (32'h8020_0003),
        .PRESCALE   (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .step_n_i   (step_n),
        .load_i     (load),
        .seed_i     (seed),
`ifdef LFSR_DIGIT_HOLD_EN
        .hold_i     (hold),
`endif
        .lfsr_o     (lfsr),
        .digits_o   (digits),
        .advance_o  (advance),
        .zero_fix_o (zero_fix)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] galois(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic sn, input logic ld, input logic [31:0] sd);
        run    = r;
        step_n = sn;
        load   = ld;
        seed   = sd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] seq [3];
        logic [31:0] exp_lfsr;
        logic [31:0] exp_dig;
        seq[0] = 32'h8020_0003;
        seq[1] = 32'hC030_0002;
        seq[2] = 32'h6018_0001;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef LFSR_DIGIT_HOLD_EN
        hold = 1'b0;
`endif
        stepCycle();
        stepCycle();
        checkOutput("rst_lfsr", lfsr, 32'hACE1_2468);
        checkOutput("rst_digits", digits, 32'hACE1_2468);
        checkOutput("rst_adv", 32'(advance), 32'h0);
        checkOutput("rst_zfix", 32'(zero_fix), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("post_rst_lfsr", lfsr, 32'hACE1_2468);
        checkOutput("post_rst_digits", digits, 32'hACE1_2468);

        $display("[TB] load seed 1 and free-run");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0001);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("load1_lfsr", lfsr, 32'h0000_0001);
        checkOutput("load1_adv", 32'(advance), 32'h0);
        checkOutput("load1_digits_lag", digits, 32'hACE1_2468);
        stepCycle();
        checkOutput("load1_digits", digits, 32'h0000_0001);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        exp_lfsr = 32'h0000_0001;
        for (int i = 1; i <= 12; i++) begin
            exp_dig = exp_lfsr;
            stepCycle();
            if (i % 4 == 0) exp_lfsr = galois(exp_lfsr);
            checkOutput("run_adv", 32'(advance), 32'(i % 4 == 0));
            checkOutput("run_lfsr", lfsr, exp_lfsr);
            checkOutput("run_digits", digits, exp_dig);
            if (i % 4 == 0) checkOutput("run_seq", lfsr, seq[i / 4 - 1]);
        end

        $display("[TB] manual step with glitches");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int g = 0; g < 2; g++) begin
            step_n = 1'b0;
            stepCycle();
            checkOutput("glitch_adv", 32'(advance), 32'h0);
            step_n = 1'b1;
            for (int k = 0; k < 5; k++) begin
                stepCycle();
                checkOutput("glitch_adv", 32'(advance), 32'h0);
            end
        end
        checkOutput("glitch_lfsr", lfsr, 32'h6018_0001);

        step_n = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            stepCycle();
            checkOutput("press_adv", 32'(advance), 32'(j == 5));
            if (j == 5) checkOutput("press_lfsr", lfsr, 32'hB02C_0003);
        end
        step_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            stepCycle();
            checkOutput("release_adv", 32'(advance), 32'h0);
        end
        checkOutput("release_lfsr", lfsr, 32'hB02C_0003);

        $display("[TB] zero seed substitution");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("zero_lfsr", lfsr, 32'hACE1_2468);
        checkOutput("zero_zfix", 32'(zero_fix), 32'h1);
        checkOutput("zero_adv", 32'(advance), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_00FF);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("nz_lfsr", lfsr, 32'h0000_00FF);
        checkOutput("nz_zfix_sticky", 32'(zero_fix), 32'h1);

        $display("[TB] load against coincident tick");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int j = 0; j < 3; j++) begin
            stepCycle();
            checkOutput("pre_tick_adv", 32'(advance), 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("coinc_lfsr", lfsr, 32'h1234_5678);
        checkOutput("coinc_adv", 32'(advance), 32'h0);
        for (int j = 1; j <= 4; j++) begin
            stepCycle();
            checkOutput("after_adv", 32'(advance), 32'(j == 4));
            checkOutput("after_lfsr", lfsr, (j == 4) ? 32'h091A_2B3C : 32'h1234_5678);
        end
        checkOutput("after_zfix", 32'(zero_fix), 32'h1);

`ifdef LFSR_DIGIT_HOLD_EN
        $display("[TB] display hold");
        exp_lfsr = 32'h091A_2B3C;
        hold = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            stepCycle();
            if (j % 4 == 0) exp_lfsr = galois(exp_lfsr);
            checkOutput("hold_digits", digits, 32'h1234_5678);
            checkOutput("hold_lfsr", lfsr, exp_lfsr);
        end
        checkOutput("hold_lfsr_final", lfsr, 32'h0246_8ACF);
        hold = 1'b0;
        stepCycle();
        checkOutput("unhold_digits", digits, 32'h0246_8ACF);
`endif

        $display("[TB] reset mid-count");
        rst_n = 1'b0;
        stepCycle();
        checkOutput("rst2_lfsr", lfsr, 32'hACE1_2468);
        checkOutput("rst2_zfix", 32'(zero_fix), 32'h0);
        rst_n = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            stepCycle();
            checkOutput("rst2_adv", 32'(advance), 32'(j == 4));
        end
        checkOutput("rst2_shift", lfsr, galois(32'hACE1_2468));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr32_digit_source.md
Name: lfsr32_digit_source

Overview:
Upstream source stage for the eight HEX digit decoders of the LFSR_32bit demo on the DE2-115.
- Holds a 32-bit Galois LFSR.
- Advances it either free-running from a prescaled tick or one step per debounced push-button press.
- Supports a synchronous seed load.
- Presents the state as eight packed 4-bit nibbles, one per 7-segment decoder.

Parameters:
SEED, 32'hACE1_2468, reset value and fallback seed; must be non-zero.
TAPS, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
PRESCALE, 50_000_000, clk cycles per free-run advance (1 Hz at 50 MHz); minimum 2.
DEB_CYCLES, 1_000_000, cycles the synchronised button must be stable before it is accepted (20 ms); minimum 1.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
run_i  in  1  level, synchronous (slide switch): 1 = free-run mode, 0 = manual step mode
step_n_i  in  1  raw, asynchronous, active-low push button (KEY)
load_i  in  1  synchronous one-cycle pulse: load seed_i
seed_i  in  32  seed value sampled when load_i=1
lfsr_o  out  32  current LFSR state
digits_o  out  32  registered display copy; digits_o[4k+3:4k] feeds HEX digit k
advance_o  out  1  one-cycle pulse, high in the cycle lfsr_o takes a shifted value
zero_fix_o  out  1  sticky flag: a zero seed was rejected and SEED substituted

Behaviour:
Reset (rst_n=0, asynchronous):
- lfsr_o=SEED, digits_o=SEED, advance_o=0, zero_fix_o=0.
- Prescaler and debounce counters = 0.
- Synchroniser flops and debounced button level = 1 (released).

Button path:
- step_n_i passes through a 2-flop synchroniser.
- Debounce counter clears whenever the synchronised level equals the debounced level; otherwise it increments.
- When the counter reaches DEB_CYCLES-1, the debounced level takes the synchronised level and the counter clears.
- step_pulse = one-cycle pulse on the 1->0 transition of the debounced level.
- Button release generates no pulse.
- Latency from a clean press to step_pulse: 2 + DEB_CYCLES cycles.

Prescaler:
- While run_i=1: counts 0..PRESCALE-1 and wraps; tick=1 in the cycle the count equals PRESCALE-1.
- While run_i=0: held at 0, tick=0.
- After run_i rises, the first tick occurs PRESCALE cycles later.

Advance:
- advance = (run_i & tick) | (~run_i & step_pulse).
- step_pulse is ignored while run_i=1.
- Ticks cannot occur while run_i=0.

LFSR update (registered, priority order):
1. load_i=1: lfsr_o <= (seed_i==0) ? SEED : seed_i. zero_fix_o <= 1 if seed_i==0. advance_o=0 that cycle. A coincident advance is dropped, not deferred.
2. advance=1: lfsr_o <= {1'b0, lfsr_o[31:1]} ^ (lfsr_o[0] ? TAPS : 32'h0); advance_o=1.
3. Otherwise: hold.

LFSR constraints:
- The all-zero state is unreachable. If ever detected (SEU), lfsr_o <= SEED on the next cycle without asserting advance_o.
- zero_fix_o clears only on reset.

Display:
- digits_o <= lfsr_o every cycle.
- A change on lfsr_o appears on digits_o exactly 1 cycle later.

Reset mid-press or mid-count: all counters return to 0. A button held through reset release produces no pulse until it is released and pressed again.

Optional Feature:
Macro LFSR_DIGIT_HOLD_EN.
- Defined: adds input hold_i (1 bit, level, synchronous). While hold_i=1, digits_o freezes at its current value and the LFSR, advance_o and load continue normally. On hold_i falling, digits_o resumes tracking lfsr_o with 1-cycle latency.
- Undefined: no hold_i port; digits_o always tracks lfsr_o.

Test Plan:
Sim parameters: PRESCALE=4, DEB_CYCLES=3, TAPS default.
- Reset release -> lfsr_o=digits_o=32'hACE1_2468, advance_o=0, zero_fix_o=0.
- load_i=1 with seed_i=32'h0000_0001, then run_i=1 for 12 cycles -> advance_o pulses every 4th cycle; lfsr_o sequence 32'h8020_0003, 32'hC030_0002, 32'h6018_0001; digits_o lags by 1 cycle.
- run_i=0, step_n_i low with 1-cycle glitches, then a clean low held 10 cycles -> exactly one advance_o, 5 cycles after the clean edge; glitches and release produce none.
- load_i=1 with seed_i=0 -> lfsr_o=32'hACE1_2468, zero_fix_o=1 and stays 1 through later loads of non-zero seeds.
- load_i coincident with a prescaler tick, seed_i=32'h1234_5678 -> lfsr_o=32'h1234_5678, advance_o=0; next tick shifts from that value.
- LFSR_DIGIT_HOLD_EN: hold_i=1 for 8 free-run cycles -> digits_o constant while lfsr_o advances twice; hold_i=0 -> digits_o=lfsr_o one cycle later.
